instruction_fetch_unit: RTL and testbench

- Consumer side of the instruction ROM interface: drives the 16-bit ROM address and captures the returned 28-bit instruction word.
- Presents one registered instruction per cycle to the decode/ALU stage.
- Executes NOP-delay instructions locally by inserting bubbles, and redirects the program counter on taken branches/jumps from the execute stage.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: ROM address/data, decode output and execute-stage redirect.
// The master side is the fetch unit; the slave side is ROM, decode and execute.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 28
);
    logic [ADDR_W-1:0] oAddress;
    logic [INSN_W-1:0] iInstruction;
    logic [INSN_W-1:0] oInstruction;
    logic              oValid;
    logic              oBusy;
    logic              iStall;
    logic              iBranchTaken;
    logic [ADDR_W-1:0] iBranchTarget;

    modport master (
        output oAddress,
        output oInstruction,
        output oValid,
        output oBusy,
        input  iInstruction,
        input  iStall,
        input  iBranchTaken,
        input  iBranchTarget
    );

    modport slave (
        input  oAddress,
        input  oInstruction,
        input  oValid,
        input  oBusy,
        output iInstruction,
        output iStall,
        output iBranchTaken,
        output iBranchTarget
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC/ROM addressing, registered issue, local NOP-delay bubbles
// and branch redirect from execute.
module instruction_fetch_unit #(
    parameter int         ADDR_W     = 16,
    parameter int         INSN_W     = 28,
    parameter logic [3:0] NOP_OPCODE = 4'd0
) (
    input logic                     Clock,
    input logic                     Reset,
    instruction_fetch_unit_if.master bus
);
    localparam int CNT_W = INSN_W - 4;

    typedef enum logic {
        FETCH,
        DELAY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn_q;
    logic              valid_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt;

    logic              is_nop;
    logic [CNT_W-1:0]  nop_len;

    assign is_nop  = (bus.iInstruction[INSN_W-1 -: 4] == NOP_OPCODE);
    assign nop_len = bus.iInstruction[CNT_W-1:0];

    assign bus.oAddress     = pc;
    assign bus.oInstruction = insn_q;
    assign bus.oValid       = valid_q;
    assign bus.oBusy        = busy_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= FETCH;
            pc      <= '0;
            insn_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt     <= '0;
        end else if (bus.iBranchTaken) begin
            // The word on the ROM bus belongs to the wrong path: squash it.
            state   <= FETCH;
            pc      <= bus.iBranchTarget;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt     <= '0;
        end else if (!bus.iStall) begin
            unique case (state)
                FETCH: begin
                    insn_q  <= bus.iInstruction;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    pc      <= pc + ADDR_W'(1);
                    if (is_nop && nop_len != '0) begin
                        state <= DELAY;
                        cnt   <= nop_len;
                    end
                end
                DELAY: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FETCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized and directed bench for instruction_fetch_unit against
// a bubble-count reference model of the fetch rules.
module tb_instruction_fetch_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [27:0] rom [65536];

    assign bus.iInstruction = rom[bus.oAddress];

    int errors = 0;
    int checks = 0;

    logic [15:0] m_pc;
    logic [27:0] m_insn;
    logic        m_valid;
    logic        m_busy;
    int          m_bub;

    wire [45:0] dut_obs = {bus.oAddress, bus.oInstruction, bus.oValid, bus.oBusy};

    function automatic logic [45:0] m_obs();
        return {m_pc, m_insn, m_valid, m_busy};
    endfunction

    function automatic logic [27:0] op(input logic [3:0] o);
        return {o, 24'($urandom)};
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_insn = '0;
        m_valid = 1'b0;
        m_busy = 1'b0;
        m_bub = 0;
    endtask

    // One clock edge: drive inputs, advance the model, settle 1 time unit.
    task automatic cycle(input bit st, input bit br, input logic [15:0] tg);
        bus.iStall = st;
        bus.iBranchTaken = br;
        bus.iBranchTarget = tg;
        @(posedge Clock);
        if (br) begin
            m_pc = tg;
            m_valid = 1'b0;
            m_busy = 1'b0;
            m_bub = 0;
        end else if (!st) begin
            if (m_bub > 0) begin
                m_bub--;
                m_valid = 1'b0;
                m_busy = 1'b1;
            end else begin
                m_insn = rom[m_pc];
                m_valid = 1'b1;
                m_busy = 1'b0;
                m_pc = m_pc + 16'd1;
                if (m_insn[27:24] == 4'd0) m_bub = int'(m_insn[23:0]);
            end
        end
        #1;
        bus.iStall = 1'b0;
        bus.iBranchTaken = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs !== 46'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want 0", dut_obs);
        end
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (dut_obs !== 46'd0) begin
            errors++;
            $display("FAIL reset_held: got %h want 0", dut_obs);
        end
        @(negedge Clock) Reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 16'h0);
            checks++;
            if (bus.oAddress !== 16'(i + 1) || bus.oValid !== 1'b1 ||
                bus.oInstruction !== rom[i] || dut_obs !== m_obs()) begin
                errors++;
                $display("FAIL seq[%0d]: got %h want %h", i, dut_obs, m_obs());
            end
        end
    endtask

    task automatic test_nop_delay();
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oValid !== 1'b1 || bus.oBusy !== 1'b0 ||
            bus.oInstruction !== rom[5] || bus.oAddress !== 16'd6) begin
            errors++;
            $display("FAIL nop_issue: got %h want %h", dut_obs, m_obs());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0);
            checks++;
            if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b1 ||
                bus.oAddress !== 16'd6 || dut_obs !== m_obs()) begin
                errors++;
                $display("FAIL nop_bubble[%0d]: got %h want %h", i, dut_obs, m_obs());
            end
        end
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oValid !== 1'b1 || bus.oBusy !== 1'b0 ||
            bus.oInstruction !== rom[6] || bus.oAddress !== 16'd7) begin
            errors++;
            $display("FAIL nop_resume: got %h want %h", dut_obs, m_obs());
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 8 && m_pc != 16'd10; i++) cycle(0, 0, 16'h0);
        checks++;
        if (bus.oAddress !== 16'd10) begin
            errors++;
            $display("FAIL br_setup: got addr %h want 000a", bus.oAddress);
        end
        cycle(0, 1, 16'h0008);
        checks++;
        if (bus.oAddress !== 16'd8 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL br_redirect: got %h want %h", dut_obs, m_obs());
        end
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oInstruction !== rom[8] || bus.oValid !== 1'b1 ||
            bus.oAddress !== 16'd9) begin
            errors++;
            $display("FAIL br_target: got %h want %h", dut_obs, m_obs());
        end
    endtask

    task automatic test_stall();
        logic [45:0] snap;
        int bubbles;
        cycle(0, 1, 16'd3);
        snap = dut_obs;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 16'h0);
            checks++;
            if (dut_obs !== snap || dut_obs !== m_obs()) begin
                errors++;
                $display("FAIL stall_fetch[%0d]: got %h want %h", i, dut_obs, snap);
            end
        end
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oAddress !== 16'd4 || bus.oInstruction !== rom[3] || bus.oValid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", dut_obs, m_obs());
        end
        cycle(0, 1, 16'h0020);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        snap = dut_obs;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 16'h0);
            checks++;
            if (dut_obs !== snap || dut_obs !== m_obs()) begin
                errors++;
                $display("FAIL stall_delay[%0d]: got %h want %h", i, dut_obs, snap);
            end
        end
        bubbles = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 16'h0);
            if (bus.oValid === 1'b1) break;
            if (bus.oBusy === 1'b1) bubbles++;
        end
        checks++;
        if (bubbles != 2 || bus.oValid !== 1'b1 || bus.oInstruction !== rom[16'h21]) begin
            errors++;
            $display("FAIL stall_bubbles: got %0d bubbles insn %h want 2 insn %h",
                     bubbles, bus.oInstruction, rom[16'h21]);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 16'hFFFF);
        checks++;
        if (bus.oAddress !== 16'hFFFF || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_preset: got %h want %h", dut_obs, m_obs());
        end
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oAddress !== 16'h0000 || bus.oInstruction !== rom[16'hFFFF] ||
            bus.oValid !== 1'b1 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL wrap: got %h want %h", dut_obs, m_obs());
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 16'h0100);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oBusy !== 1'b1 || dut_obs !== m_obs()) begin
            errors++;
            $display("FAIL arst_setup: got %h want %h", dut_obs, m_obs());
        end
        #2 Reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs !== 46'd0) begin
            errors++;
            $display("FAIL arst_immediate: got %h want 0", dut_obs);
        end
        @(negedge Clock) Reset = 1'b1;
        cycle(0, 0, 16'h0);
        checks++;
        if (bus.oAddress !== 16'd1 || bus.oInstruction !== rom[0] ||
            bus.oValid !== 1'b1 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL arst_restart: got %h want %h", dut_obs, m_obs());
        end
    endtask

    task automatic test_random();
        bit st;
        bit br;
        logic [15:0] tg;
        for (int i = 0; i < 600; i++) begin
            st = ($urandom % 5) == 0;
            br = ($urandom % 14) == 0;
            tg = ($urandom % 4 == 0) ? 16'(16'hFFFC + $urandom % 4) : 16'($urandom);
            cycle(st, br, tg);
            checks++;
            if (dut_obs !== m_obs()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_obs, m_obs());
            end
        end
    endtask

    initial begin
        bus.iStall = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchTarget = '0;
        for (int a = 0; a < 65536; a++) begin
            if ($urandom % 6 == 0) rom[a] = {4'd0, 24'($urandom % 5)};
            else rom[a] = op(4'($urandom_range(1, 15)));
        end
        rom[0] = op(4'd1);
        rom[1] = op(4'd2);
        rom[2] = op(4'd2);
        rom[3] = op(4'd3);
        rom[4] = op(4'd1);
        rom[5] = {4'd0, 24'd3};
        for (int a = 6; a <= 10; a++) rom[a] = op(4'($urandom_range(1, 15)));
        rom[16'h0020] = {4'd0, 24'd4};
        rom[16'h0021] = op(4'd5);
        rom[16'h0100] = {4'd0, 24'd4002};
        rom[16'hFFFF] = op(4'd7);

        test_reset();
        test_sequential();
        test_nop_delay();
        test_branch();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
